// File: rtl/id_allocator_if.sv
// Allocation, free and restore signals of the ID allocator, grouped in one bundle.
// master drives the requests; slave is the allocator itself.
interface id_allocator_if #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4
);
    localparam int UID_W = $clog2(NUM_ROWS) + $clog2(NUM_COLS);

    // valid/ready: an allocation commits on any rising edge where alloc_valid && alloc_ready;
    // alloc_uid is meaningful only then. free_req has no backpressure and is never stalled.
    logic                alloc_valid;
    logic [ID_WIDTH-1:0] alloc_orig_id;
    logic                alloc_ready;
    logic [UID_W-1:0]    alloc_uid;
    logic                free_req;
    logic [UID_W-1:0]    free_uid;
    logic [UID_W-1:0]    restore_uid;
    logic [ID_WIDTH-1:0] restored_id;
    logic                free_err;

    modport master (
        output alloc_valid, alloc_orig_id, free_req, free_uid, restore_uid,
        input  alloc_ready, alloc_uid, restored_id, free_err
    );

    modport slave (
        input  alloc_valid, alloc_orig_id, free_req, free_uid, restore_uid,
        output alloc_ready, alloc_uid, restored_id, free_err
    );
endinterface

// File: rtl/id_allocator.sv
// Maps original AXI IDs onto unique {row,col} IDs; one row is owned by one original ID at a time.
// Optional ID_ALLOCATOR_STATS_EN adds a registered outstanding_total count.
module id_allocator #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4
) (
    input  logic clk,
    input  logic rst,
    id_allocator_if.slave bus
`ifdef ID_ALLOCATOR_STATS_EN
    ,
    output logic [$clog2(NUM_ROWS*NUM_COLS):0] outstanding_total
`endif
);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int UID_W = ROW_W + COL_W;
    localparam int CNT_W = COL_W + 1;

    logic                owned     [NUM_ROWS];
    logic [ID_WIDTH-1:0] owner_id  [NUM_ROWS];
    logic [COL_W-1:0]    alloc_ptr [NUM_ROWS];
    logic [CNT_W-1:0]    count     [NUM_ROWS];

    logic             match_found;
    logic [ROW_W-1:0] match_row;
    logic             empty_found;
    logic [ROW_W-1:0] empty_row;
    logic [ROW_W-1:0] sel_row;
    logic [ROW_W-1:0] free_row;
    logic [ROW_W-1:0] restore_row;
    logic             alloc_hs;
    logic             free_ok;
    logic             free_bad;
    logic             free_err_q;
    logic [NUM_ROWS-1:0] row_inc;
    logic [NUM_ROWS-1:0] row_dec;

    // Row indices are the upper bits of a UID; the shift keeps the whole UID in the expression.
    assign free_row    = ROW_W'(bus.free_uid >> COL_W);
    assign restore_row = ROW_W'(bus.restore_uid >> COL_W);

    always_comb begin
        match_found = 1'b0;
        match_row   = '0;
        empty_found = 1'b0;
        empty_row   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (owned[r] && (owner_id[r] == bus.alloc_orig_id)) begin
                match_found = 1'b1;
                match_row   = ROW_W'(r);
            end
            if (!owned[r] && !empty_found) begin
                empty_found = 1'b1;
                empty_row   = ROW_W'(r);
            end
        end
    end

    // A matching row takes priority even when full, so one ID never spans two rows.
    always_comb begin
        sel_row         = match_found ? match_row : empty_row;
        bus.alloc_ready = match_found ? (count[match_row] != CNT_W'(NUM_COLS)) : empty_found;
        bus.alloc_uid   = {sel_row, alloc_ptr[sel_row]};
        bus.restored_id = owner_id[restore_row];
    end

    assign alloc_hs     = bus.alloc_valid && bus.alloc_ready;
    assign free_ok      = bus.free_req && (count[free_row] != '0);
    assign free_bad     = bus.free_req && (count[free_row] == '0);
    assign bus.free_err = free_err_q;

    always_comb begin
        row_inc = '0;
        row_dec = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_inc[r] = alloc_hs && (sel_row == ROW_W'(r));
            row_dec[r] = free_ok && (free_row == ROW_W'(r));
        end
    end

    // alloc_ptr is never cleared outside reset so it tracks the consumer's release pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                owned[r]     <= 1'b0;
                owner_id[r]  <= '0;
                alloc_ptr[r] <= '0;
                count[r]     <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (row_inc[r]) begin
                    alloc_ptr[r] <= alloc_ptr[r] + COL_W'(1);
                    owner_id[r]  <= bus.alloc_orig_id;
                    owned[r]     <= 1'b1;
                end
                case ({row_inc[r], row_dec[r]})
                    2'b10: count[r] <= count[r] + CNT_W'(1);
                    2'b01: begin
                        count[r] <= count[r] - CNT_W'(1);
                        owned[r] <= (count[r] != CNT_W'(1));
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) free_err_q <= 1'b0;
        else     free_err_q <= free_bad;
    end

`ifdef ID_ALLOCATOR_STATS_EN
    localparam int TOT_W = $clog2(NUM_ROWS*NUM_COLS) + 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_total <= '0;
        end else begin
            case ({alloc_hs, free_ok})
                2'b10:   outstanding_total <= outstanding_total + TOT_W'(1);
                2'b01:   outstanding_total <= outstanding_total - TOT_W'(1);
                default: ;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_id_allocator.sv
// Directed bench for id_allocator: hand-computed UIDs, backpressure, wraparound and free errors.
module tb_id_allocator;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miscmp;

    id_allocator_if #(.ID_WIDTH(4), .NUM_ROWS(4), .NUM_COLS(4)) bus ();

`ifdef ID_ALLOCATOR_STATS_EN
    logic [4:0] outstanding_total;
`endif

    id_allocator #(.ID_WIDTH(4), .NUM_ROWS(4), .NUM_COLS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ID_ALLOCATOR_STATS_EN
        ,
        .outstanding_total(outstanding_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_total(input string tag, input int exp);
`ifdef ID_ALLOCATOR_STATS_EN
        check(tag, 32'(outstanding_total), exp);
`endif
    endtask

    task automatic idle_inputs();
        bus.alloc_valid   = 1'b0;
        bus.alloc_orig_id = '0;
        bus.free_req      = 1'b0;
        bus.free_uid      = '0;
        bus.restore_uid   = '0;
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic alloc_chk(input string tag, input logic [3:0] id, input logic [3:0] exp_uid);
        bus.alloc_valid   = 1'b1;
        bus.alloc_orig_id = id;
        @(negedge clk);
        check({tag, "_rdy"}, bus.alloc_ready, 1);
        check({tag, "_uid"}, bus.alloc_uid, exp_uid);
        @(posedge clk);
        #1;
        bus.alloc_valid = 1'b0;
    endtask

    // Looks at the allocation response without committing it.
    task automatic probe(input string tag, input logic [3:0] id, input logic exp_rdy,
                         input logic [3:0] exp_uid);
        bus.alloc_valid   = 1'b1;
        bus.alloc_orig_id = id;
        @(negedge clk);
        check({tag, "_rdy"}, bus.alloc_ready, exp_rdy);
        if (exp_rdy) check({tag, "_uid"}, bus.alloc_uid, exp_uid);
        bus.alloc_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic free_op(input logic [3:0] uid);
        bus.free_req = 1'b1;
        bus.free_uid = uid;
        @(posedge clk);
        #1;
        bus.free_req = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        idle_inputs();

        // Requests presented during reset must be discarded.
        bus.alloc_valid   = 1'b1;
        bus.alloc_orig_id = 4'h7;
        bus.free_req      = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_free_err", bus.free_err, 0);
        check("rst_ready", bus.alloc_ready, 1);
        check("rst_uid", bus.alloc_uid, 0);
        check_total("rst_total", 0);
        @(posedge clk);
        #1;
        probe("rst_any_id", 4'hE, 1'b1, 4'h0);

        // Three allocations of one ID fill row 0 in order; restore reads the owner.
        alloc_chk("a5_0", 4'h5, 4'h0);
        alloc_chk("a5_1", 4'h5, 4'h1);
        alloc_chk("a5_2", 4'h5, 4'h2);
        bus.restore_uid = 4'h1;
        @(negedge clk);
        check("restore_1", bus.restored_id, 4'h5);
        check_total("total_3", 3);
        @(posedge clk);
        #1;

        // A different ID goes to the next free row.
        do_reset();
        alloc_chk("row0", 4'h5, 4'h0);
        alloc_chk("row1", 4'h9, 4'h4);

        // Full row backpressures its ID; a free lets the wrapped pointer reuse col 0.
        do_reset();
        alloc_chk("full_0", 4'h5, 4'h0);
        alloc_chk("full_1", 4'h5, 4'h1);
        alloc_chk("full_2", 4'h5, 4'h2);
        alloc_chk("full_3", 4'h5, 4'h3);
        probe("full_5th", 4'h5, 1'b0, 4'h0);
        bus.alloc_valid   = 1'b1;
        bus.alloc_orig_id = 4'h5;
        bus.free_req      = 1'b1;
        bus.free_uid      = 4'h0;
        @(negedge clk);
        check("full_free_cyc_rdy", bus.alloc_ready, 0);
        @(posedge clk);
        #1;
        bus.free_req = 1'b0;
        alloc_chk("full_wrap", 4'h5, 4'h0);
        check_total("full_total", 4);

        // All rows owned; a freed row is reusable only from the next cycle, pointer continued.
        do_reset();
        alloc_chk("own_r0", 4'h1, 4'h0);
        alloc_chk("own_r1", 4'h2, 4'h4);
        alloc_chk("own_r2a", 4'h3, 4'h8);
        alloc_chk("own_r2b", 4'h3, 4'h9);
        free_op(4'h8);
        alloc_chk("own_r3", 4'h4, 4'hC);
        probe("own_none", 4'hA, 1'b0, 4'h0);
        bus.alloc_valid   = 1'b1;
        bus.alloc_orig_id = 4'hA;
        bus.free_req      = 1'b1;
        bus.free_uid      = 4'h9;
        bus.restore_uid   = 4'h9;
        @(negedge clk);
        check("own_free_cyc_rdy", bus.alloc_ready, 0);
        check("own_free_restore", bus.restored_id, 4'h3);
        @(posedge clk);
        #1;
        bus.free_req = 1'b0;
        @(negedge clk);
        check("own_after_restore", bus.restored_id, 4'h3);
        bus.alloc_valid = 1'b0;
        @(posedge clk);
        #1;
        alloc_chk("own_reuse", 4'hA, 4'hA);

        // Simultaneous alloc and free on the same row keeps it owned with count 1.
        do_reset();
        alloc_chk("same_first", 4'h5, 4'h0);
        bus.alloc_valid   = 1'b1;
        bus.alloc_orig_id = 4'h5;
        bus.free_req      = 1'b1;
        bus.free_uid      = 4'h0;
        @(negedge clk);
        check("same_rdy", bus.alloc_ready, 1);
        check("same_uid", bus.alloc_uid, 4'h1);
        @(posedge clk);
        #1;
        idle_inputs();
        check_total("same_total", 1);
        probe("same_other_id", 4'h9, 1'b1, 4'h4);
        probe("same_owned", 4'h5, 1'b1, 4'h2);
        free_op(4'h1);
        @(negedge clk);
        check("same_cnt1_no_err", bus.free_err, 0);
        @(posedge clk);
        #1;
        free_op(4'h1);
        @(negedge clk);
        check("same_cnt0_err", bus.free_err, 1);
        @(posedge clk);
        #1;

        // Free to an empty row: one-cycle error pulse, nothing else moves.
        do_reset();
        alloc_chk("err_setup", 4'h5, 4'h0);
        bus.free_req = 1'b1;
        bus.free_uid = 4'hC;
        @(negedge clk);
        check("err_pre", bus.free_err, 0);
        @(posedge clk);
        #1;
        bus.free_req = 1'b0;
        @(negedge clk);
        check("err_pulse", bus.free_err, 1);
        check_total("err_total", 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("err_cleared", bus.free_err, 0);
        @(posedge clk);
        #1;
        alloc_chk("err_state", 4'h5, 4'h1);
        probe("err_row1", 4'h6, 1'b1, 4'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
